// File: rtl/serial_link_slave_pkg.sv
// Shared constants for the serial link responder: register addresses,
// FSM state encoding and SC bit positions.
package serial_link_slave_pkg;

  localparam logic [15:0] ADDR_SB = 16'hFF01;
  localparam logic [15:0] ADDR_SC = 16'hFF02;

  localparam int SC_START_BIT  = 7;
  localparam int SC_CLKSEL_BIT = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } link_state_t;

endpackage

// File: rtl/serial_sync_edge.sv
// Multi-flop synchronizer with edge detection on the synchronized level.
// The chain resets to 1 because the link idles high.
module serial_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain plus one-cycle-delayed copy for edge compare
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/serial_link_slave.sv
// Serial link responder (external clock only). SB shift register at FF01,
// SC control at FF02. Optional idle-clock abort enabled by defining the
// macro SERIAL_TIMEOUT_EN.
module serial_link_slave
  import serial_link_slave_pkg::*;
#(
  parameter int          SYNC_STAGES    = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  input  logic        rd,
  input  logic        wr,
  output logic        int_serial_req,
  input  logic        int_serial_ack,
  input  logic        sck_in,
  input  logic        sin,
  output logic        sout
);

  link_state_t r_state, w_state_nxt;
  logic [7:0]  r_sb;
  logic        r_start, r_clk_sel;
  logic [2:0]  r_bit_cnt;
  logic        r_int_req, r_sout;
  logic [SYNC_STAGES-1:0] r_sin_sync;

  logic w_sck_s, w_sck_rise, w_sck_fall, w_sin_s;
  logic w_sb_wr, w_sc_wr, w_cpu_wr, w_go, w_active;
  logic w_rise_ok, w_fall_ok, w_done, w_timeout;
  logic w_unused;

  serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk     (clk),
    .rst     (rst),
    .i_d     (sck_in),
    .o_level (w_sck_s),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  // Plain synchronizer for link data, idle high
  always_ff @(posedge clk) begin
    if (rst) r_sin_sync <= '1;
    else     r_sin_sync <= {r_sin_sync[SYNC_STAGES-2:0], sin};
  end
  assign w_sin_s = r_sin_sync[SYNC_STAGES-1];

  assign w_sb_wr  = wr && (a == ADDR_SB);
  assign w_sc_wr  = wr && (a == ADDR_SC);
  assign w_cpu_wr = w_sb_wr || w_sc_wr;
  assign w_go     = w_sc_wr && din[SC_START_BIT] && !din[SC_CLKSEL_BIT];
  assign w_active = (r_state == ST_SHIFT) && r_start && !r_clk_sel;
  // A CPU write in the same cycle drops the sck edge entirely
  assign w_rise_ok = w_active && w_sck_rise && !w_cpu_wr;
  assign w_fall_ok = w_active && w_sck_fall && !w_cpu_wr;
  assign w_done    = w_rise_ok && (r_bit_cnt == 3'd7);

`ifdef SERIAL_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  // Idle-clock counter: runs mid-byte, restarts on every rising sck edge
  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_IDLE) || w_rise_ok) r_to_cnt <= '0;
    else if ((r_bit_cnt != 3'd0) && !w_timeout)   r_to_cnt <= r_to_cnt + 16'd1;
  end
  assign w_timeout = (r_state == ST_SHIFT) && (r_to_cnt >= TIMEOUT_CYCLES) && !w_cpu_wr;
`else
  // The limit only has meaning with the counter present
  localparam logic [15:0] unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state: CPU writes take precedence over completion/abort
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_go) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (w_sc_wr && !din[SC_START_BIT]) w_state_nxt = ST_IDLE;
        else if (w_done || w_timeout)      w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift register, control bits, bit counter, interrupt and link output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb      <= 8'h00;
      r_start   <= 1'b0;
      r_clk_sel <= 1'b0;
      r_bit_cnt <= 3'd0;
      r_int_req <= 1'b0;
      r_sout    <= 1'b0;
    end else begin
      if (w_sb_wr)        r_sb <= din;
      else if (w_rise_ok) r_sb <= {r_sb[6:0], w_sin_s};

      if (w_sc_wr) begin
        r_start   <= din[SC_START_BIT];
        r_clk_sel <= din[SC_CLKSEL_BIT];
      end else if (w_done || w_timeout) begin
        r_start   <= 1'b0;
      end

      if (w_go && (r_state == ST_IDLE)) r_bit_cnt <= 3'd0;
      else if (w_timeout)               r_bit_cnt <= 3'd0;
      else if (w_rise_ok)               r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_done)                                          r_int_req <= 1'b1;
      else if (int_serial_ack && (r_state == ST_IDLE))     r_int_req <= 1'b0;

      if (r_state == ST_IDLE) r_sout <= r_sb[7];
      else if (w_fall_ok)     r_sout <= r_sb[7];
    end
  end

  // Combinational read mux; unmapped addresses float high
  always_comb begin
    dout = 8'hFF;
    if (a == ADDR_SB)      dout = r_sb;
    else if (a == ADDR_SC) dout = {r_start, 6'b111111, r_clk_sel};
  end

  assign int_serial_req = r_int_req;
  assign sout           = r_sout;
  // Reads have no side effects, and the synchronized sck level is only needed as edges
  assign w_unused       = &{1'b0, rd, w_sck_s};

endmodule
